// File: rtl/mig_cmd_arbiter.sv
// Arbitrates NUM_REQ requesters onto one MIG command port with urgent/normal classes,
// round-robin inside each class and address range checking. Optional counters: MIG_ARB_STAT_EN.
module mig_cmd_arbiter #(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned MAX_ADDRESS   = 3840000,
    parameter int unsigned BYTE_PER_WORD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_urgent,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [3*NUM_REQ-1:0]    req_instr,
    input  logic [30*NUM_REQ-1:0]   req_addr,
    input  logic [6*NUM_REQ-1:0]    req_bl,
    output logic                    mig_cmd_en,
    output logic [2:0]              mig_cmd_instr,
    output logic [5:0]              mig_cmd_bl,
    output logic [29:0]             mig_cmd_byte_addr,
    input  logic                    mig_cmd_full,
    output logic [1:0]              last_grant,
    output logic                    error,
    output logic [1:0]              err_req,
    output logic [16*NUM_REQ-1:0]   stat_count
);

    typedef enum logic [0:0] {
        ArbIdle,
        ArbAct
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic        cmd_en_q, cmd_en_d;
    logic [2:0]  cmd_instr_q, cmd_instr_d;
    logic [5:0]  cmd_bl_q, cmd_bl_d;
    logic [29:0] cmd_addr_q, cmd_addr_d;
    logic        error_q, error_d;
    logic [1:0]  err_req_q, err_req_d;

    logic [NUM_REQ-1:0] urgent_valid;
    logic [NUM_REQ-1:0] cand;
    logic [2:0]         scan_idx;
    logic               win_found;
    logic [1:0]         win_idx;
    logic [2:0]         sel_instr;
    logic [29:0]        sel_addr;
    logic [5:0]         sel_bl;
    logic [30:0]        end_addr;
    logic               cmd_bad;

    // Urgent requests shadow normal ones entirely; RR scan starts just after the pointer.
    always_comb begin
        urgent_valid = req_valid & req_urgent;
        cand         = (urgent_valid != '0) ? urgent_valid : req_valid;
        win_found    = 1'b0;
        win_idx      = 2'd0;
        scan_idx     = 3'd0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            scan_idx = {1'b0, rr_ptr_q} + 3'(k);
            if (scan_idx >= 3'(NUM_REQ)) begin
                scan_idx = scan_idx - 3'(NUM_REQ);
            end
            if (!win_found && cand[scan_idx[1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[1:0];
            end
        end
    end

    always_comb begin
        sel_instr = 3'd0;
        sel_addr  = 30'd0;
        sel_bl    = 6'd0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_idx == 2'(i)) begin
                sel_instr = req_instr[3*i +: 3];
                sel_addr  = req_addr[30*i +: 30];
                sel_bl    = req_bl[6*i +: 6];
            end
        end
    end

    // End address is exclusive, so landing exactly on MAX_ADDRESS is still legal.
    always_comb begin
        end_addr = {1'b0, sel_addr} + ({25'd0, sel_bl} + 31'd1) * 31'(BYTE_PER_WORD);
        cmd_bad  = (sel_addr[3:0] != 4'd0) || (end_addr > 31'(MAX_ADDRESS));
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_en_d    = 1'b0;
        cmd_instr_d = cmd_instr_q;
        cmd_bl_d    = cmd_bl_q;
        cmd_addr_d  = cmd_addr_q;
        error_d     = error_q;
        err_req_d   = err_req_q;
        req_ready   = '0;
        unique case (state_q)
            ArbIdle: begin
                if (!mig_cmd_full && win_found) begin
                    req_ready[win_idx] = 1'b1;
                    rr_ptr_d           = win_idx;
                    if (cmd_bad) begin
                        // Dropped commands keep the FSM idle so the next grant can follow at once.
                        error_d = 1'b1;
                        if (!error_q) begin
                            err_req_d = win_idx;
                        end
                    end else begin
                        cmd_en_d    = 1'b1;
                        cmd_instr_d = sel_instr;
                        cmd_bl_d    = sel_bl;
                        cmd_addr_d  = sel_addr;
                        state_d     = ArbAct;
                    end
                end
            end
            ArbAct: begin
                state_d = ArbIdle;
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ArbIdle;
            rr_ptr_q    <= 2'(NUM_REQ - 1);
            cmd_en_q    <= 1'b0;
            cmd_instr_q <= 3'd0;
            cmd_bl_q    <= 6'd0;
            cmd_addr_q  <= 30'd0;
            error_q     <= 1'b0;
            err_req_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_en_q    <= cmd_en_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_bl_q    <= cmd_bl_d;
            cmd_addr_q  <= cmd_addr_d;
            error_q     <= error_d;
            err_req_q   <= err_req_d;
        end
    end

    assign mig_cmd_en        = cmd_en_q;
    assign mig_cmd_instr     = cmd_instr_q;
    assign mig_cmd_bl        = cmd_bl_q;
    assign mig_cmd_byte_addr = cmd_addr_q;
    assign last_grant        = rr_ptr_q;
    assign error             = error_q;
    assign err_req           = err_req_q;

`ifdef MIG_ARB_STAT_EN
    logic issue;
    assign issue = (state_q == ArbIdle) && !mig_cmd_full && win_found && !cmd_bad;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_stat
        logic [15:0] cnt_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= 16'd0;
            end else if (issue && (win_idx == 2'(g)) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign stat_count[16*g +: 16] = cnt_q;
    end
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// Scoreboard bench for mig_cmd_arbiter: directed stimulus pushes expected grants/commands,
// negedge monitors pop and compare.
module tb_mig_cmd_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_urgent;
    logic [N-1:0]    req_ready;
    logic [3*N-1:0]  req_instr;
    logic [30*N-1:0] req_addr;
    logic [6*N-1:0]  req_bl;
    logic            mig_cmd_en;
    logic [2:0]      mig_cmd_instr;
    logic [5:0]      mig_cmd_bl;
    logic [29:0]     mig_cmd_byte_addr;
    logic            mig_cmd_full;
    logic [1:0]      last_grant;
    logic            error;
    logic [1:0]      err_req;
    logic [16*N-1:0] stat_count;

    mig_cmd_arbiter #(
        .NUM_REQ      (N),
        .MAX_ADDRESS  (3840000),
        .BYTE_PER_WORD(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_urgent       (req_urgent),
        .req_ready        (req_ready),
        .req_instr        (req_instr),
        .req_addr         (req_addr),
        .req_bl           (req_bl),
        .mig_cmd_en       (mig_cmd_en),
        .mig_cmd_instr    (mig_cmd_instr),
        .mig_cmd_bl       (mig_cmd_bl),
        .mig_cmd_byte_addr(mig_cmd_byte_addr),
        .mig_cmd_full     (mig_cmd_full),
        .last_grant       (last_grant),
        .error            (error),
        .err_req          (err_req),
        .stat_count       (stat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  instr;
        logic [29:0] addr;
        logic [5:0]  bl;
    } cmd_t;

    cmd_t exp_cmd_q[$];
    int   exp_grant_q[$];
    int   exp_stat[N];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   grant_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Grant monitor.
    always @(negedge clk) begin
        if (rst === 1'b1 && req_ready != '0) begin
            check("ready_onehot", 32'($countones(req_ready)), 32'd1);
            if (exp_grant_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got ready 0x%0h expected none (cycle %0d)",
                         req_ready, cyc);
            end else begin
                check("grant_idx", 32'(idx_of(req_ready)), 32'(exp_grant_q.pop_front()));
            end
            grant_cyc = cyc;
        end
    end

    // Command monitor.
    always @(negedge clk) begin
        if (mig_cmd_en === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got addr 0x%0h expected no command (cycle %0d)",
                         mig_cmd_byte_addr, cyc);
            end else begin
                cmd_t c;
                c = exp_cmd_q.pop_front();
                check("cmd_instr", 32'(mig_cmd_instr), 32'(c.instr));
                check("cmd_addr", 32'(mig_cmd_byte_addr), 32'(c.addr));
                check("cmd_bl", 32'(mig_cmd_bl), 32'(c.bl));
                check("cmd_latency", 32'(cyc - grant_cyc), 32'd1);
            end
        end
    end

    task automatic set_req(input int i, input logic [2:0] instr, input logic [29:0] addr,
                           input logic [5:0] bl);
        req_instr[3*i +: 3] = instr;
        req_addr[30*i +: 30] = addr;
        req_bl[6*i +: 6]    = bl;
    endtask

    task automatic push(input int i, input bit good);
        cmd_t c;
        exp_grant_q.push_back(i);
        if (good) begin
            c.instr = req_instr[3*i +: 3];
            c.addr  = req_addr[30*i +: 30];
            c.bl    = req_bl[6*i +: 6];
            exp_cmd_q.push_back(c);
            exp_stat[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold requests until n grants are seen, then drop the masked valids after the last edge.
    task automatic hold_grants(input int n, input logic [N-1:0] drop, input int spacing);
        int got;
        int prev;
        got  = 0;
        prev = -1;
        for (int t = 0; t < 60 && got < n; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got++;
                if (spacing > 0 && prev >= 0) check("grant_spacing", 32'(cyc - prev), 32'(spacing));
                prev = cyc;
                if (got == n) begin
                    step();
                    req_valid = req_valid & ~drop;
                end
            end
        end
        if (got != n) check("grant_timeout", 32'(got), 32'(n));
    endtask

    task automatic check_stats(input string name);
        int e;
        for (int i = 0; i < N; i++) begin
`ifdef MIG_ARB_STAT_EN
            e = exp_stat[i];
`else
            e = 0;
`endif
            check(name, 32'(stat_count[16*i +: 16]), 32'(e));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", 32'(mig_cmd_en), 32'd0);
        check("rst_instr", 32'(mig_cmd_instr), 32'd0);
        check("rst_bl", 32'(mig_cmd_bl), 32'd0);
        check("rst_addr", 32'(mig_cmd_byte_addr), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_req", 32'(err_req), 32'd0);
        check("rst_last_grant", 32'(last_grant), 32'd2);
        for (int i = 0; i < N; i++) exp_stat[i] = 0;
        check_stats("rst_stat");
        step();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_ready;
        int seen_en;
        int got;
        rst          = 1'b0;
        req_valid    = '0;
        req_urgent   = '0;
        req_instr    = '0;
        req_addr     = '0;
        req_bl       = '0;
        mig_cmd_full = 1'b0;
        do_reset();

        // Single request from requester 1.
        set_req(1, 3'b001, 30'h200, 6'd15);
        push(1, 1'b1);
        req_valid[1] = 1'b1;
        hold_grants(1, 3'b010, 0);
        repeat (2) step();
        check("single_last_grant", 32'(last_grant), 32'd1);
        check_stats("single_stat");

        // Round-robin among three normal requesters.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 3'(i), 30'(32'h1000 * (i + 1)), 6'(i));
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 1'b1);
        req_valid = 3'b111;
        hold_grants(6, 3'b111, 2);
        repeat (2) step();

        // Urgent requester 2 dominates, then RR resumes from pointer 2.
        req_urgent = 3'b100;
        repeat (3) push(2, 1'b1);
        req_valid = 3'b111;
        hold_grants(3, 3'b100, 2);
        push(0, 1'b1);
        push(1, 1'b1);
        hold_grants(2, 3'b011, 2);
        req_urgent = '0;
        repeat (2) step();

        // Backpressure blocks grants while idle.
        mig_cmd_full = 1'b1;
        set_req(0, 3'b000, 30'h4000, 6'd7);
        req_valid[0] = 1'b1;
        seen_ready = 0;
        seen_en    = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready != '0) seen_ready++;
            if (mig_cmd_en) seen_en++;
        end
        check("bp_no_ready", 32'(seen_ready), 32'd0);
        check("bp_no_en", 32'(seen_en), 32'd0);
        push(0, 1'b1);
        step();
        mig_cmd_full = 1'b0;
        @(negedge clk);
        check("bp_grant_same_cycle", 32'(req_ready), 32'd1);
        step();
        req_valid[0] = 1'b0;
        repeat (2) step();
        check_stats("stat_after_bp");

        // Range boundary: end exactly at MAX_ADDRESS is legal.
        set_req(0, 3'b001, 30'd3839744, 6'd15);
        push(0, 1'b1);
        req_valid[0] = 1'b1;
        hold_grants(1, 3'b001, 0);
        repeat (2) step();
        check("range_ok_error", 32'(error), 32'd0);

        // One word past the end from requester 2.
        set_req(2, 3'b001, 30'd3839760, 6'd15);
        push(2, 1'b0);
        req_valid[2] = 1'b1;
        hold_grants(1, 3'b100, 0);
        step();
        check("range_bad_error", 32'(error), 32'd1);
        check("range_bad_err_req", 32'(err_req), 32'd2);

        // Two more bad commands back to back: misaligned and overrun; err_req must stick.
        set_req(0, 3'b000, 30'h104, 6'd0);
        set_req(1, 3'b000, 30'd3839984, 6'd1);
        push(0, 1'b0);
        push(1, 1'b0);
        req_valid = 3'b011;
        hold_grants(2, 3'b011, 1);
        step();
        check("later_err_error", 32'(error), 32'd1);
        check("later_err_err_req", 32'(err_req), 32'd2);
        check_stats("stat_after_errors");

        // Reset while a command is on the bus.
        set_req(1, 3'b011, 30'h40, 6'd3);
        push(1, 1'b1);
        req_valid[1] = 1'b1;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1;
        end
        check("midrst_grant_seen", 32'(got), 32'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("midrst_en_before", 32'(mig_cmd_en), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_en_after", 32'(mig_cmd_en), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_last_grant", 32'(last_grant), 32'd2);
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) exp_stat[i] = 0;
        set_req(0, 3'b000, 30'h80, 6'd0);
        set_req(1, 3'b000, 30'hC0, 6'd0);
        push(0, 1'b1);
        push(1, 1'b1);
        req_valid = 3'b011;
        hold_grants(2, 3'b011, 2);
        repeat (4) step();
        check_stats("stat_final");

        check("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
        check("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mig_cmd_arbiter.md
Name: mig_cmd_arbiter

Overview:
- Shares one MIG command port between NUM_REQ requesters, e.g. display scan-out read, pixel writeback and host framebuffer loader.
- Selects one pending command using two priority classes (urgent, normal) with round-robin inside each class, and registers it onto the MIG command bus.
- Checks each command's address range before issue; out-of-range commands are dropped and flag an error.
- Sits between the per-client memory interface FSMs and the MIG user command FIFO.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..4.
- MAX_ADDRESS, 3840000, framebuffer size in bytes (1600*1200*2); commands must stay below it.
- BYTE_PER_WORD, 16, bytes per MIG data word (128-bit bus).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester command pending.
- req_urgent  input  NUM_REQ  per-requester urgent class.
- req_ready  output  NUM_REQ  command accepted this cycle (combinational).
- req_instr  input  3*NUM_REQ  MIG instruction; slice i = [3i+2:3i].
- req_addr  input  30*NUM_REQ  byte address; slice i = [30i+29:30i].
- req_bl  input  6*NUM_REQ  burst length minus 1.
- mig_cmd_en  output  1  MIG command strobe (registered).
- mig_cmd_instr  output  3  registered instruction.
- mig_cmd_bl  output  6  registered burst length minus 1.
- mig_cmd_byte_addr  output  30  registered address.
- mig_cmd_full  input  1  MIG command FIFO full.
- last_grant  output  2  index of the most recently accepted requester.
- error  output  1  sticky range/alignment error.
- err_req  output  2  requester that caused the first error.
- stat_count  output  16*NUM_REQ  per-requester issued-command counters (see Optional Feature).

Behaviour:
- Reset (rst==0 at a clock edge) applies these values:
  - mig_cmd_en=0; mig_cmd_instr=0, mig_cmd_bl=0, mig_cmd_byte_addr=0.
  - error=0, err_req=0; state=ARB_IDLE.
  - RR pointer=NUM_REQ-1, so requester 0 wins first; last_grant=NUM_REQ-1.
  - stat_count=0.
- Reset mid-command: mig_cmd_en drops at that edge; any command granted in the same cycle is lost.
- FSM states:
  - ARB_IDLE: if mig_cmd_full==0 and any req_valid, grant winner w. If none, stay.
  - ARB_ACT: mig_cmd_en<=0, req_ready=0, return to ARB_IDLE.
- Winner selection, combinational:
  - Candidate set = valid & urgent if that is nonzero, else all valid.
  - Within the set, pick the first index after the RR pointer, wrapping modulo NUM_REQ.
- Grant in cycle T:
  - req_ready[w]=1 in cycle T only; exactly one bit of req_ready is ever high.
  - RR pointer and last_grant <= w.
- Range check, with end = addr + (bl+1)*BYTE_PER_WORD computed at 31 bits:
  - Bad if addr[3:0]!=0 or end > MAX_ADDRESS.
  - end == MAX_ADDRESS is legal.
- Good command:
  - mig_cmd_* registered from slice w at T+1, with mig_cmd_en=1 for exactly one cycle.
  - FSM enters ARB_ACT; the next grant is no earlier than T+2, giving at most 1 command per 2 cycles.
- Bad command:
  - Still acknowledged (req_ready[w]=1) but mig_cmd_en stays 0; FSM stays in ARB_IDLE, so the next grant can occur at T+1.
  - error<=1. err_req<=w only if error was 0; later errors do not overwrite it. error clears only on reset.
- mig_cmd_full is sampled only in ARB_IDLE. Full while in ARB_ACT has no effect. Full while idle blocks the grant; req_ready stays 0.
- Requester rule: req_instr/addr/bl must be held stable while req_valid=1 and req_ready=0. The arbiter never drops a valid request unacknowledged.
- Instructions pass through unmodified; range check applies to every instruction.

Optional Feature:
- Macro MIG_ARB_STAT_EN.
- Defined: stat_count slice i is a 16-bit counter incremented on every good command issued for requester i. It saturates at 16'hFFFF and resets to 0. Dropped commands are not counted.
- Undefined: stat_count is tied to 0 and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Single request: req 1 valid, addr 0x200, bl 15, instr 001, from cycle T → req_ready[1] high at T only; mig_cmd_en at T+1 with addr 0x200, bl 15, instr 001; stat_count[1]=1.
- Round-robin: all three valid, non-urgent, held for 6 grants → grant order 0,1,2,0,1,2; grants spaced exactly 2 cycles apart.
- Urgency: req 0 and 1 normal, req 2 urgent, all continuously valid → req 2 wins every grant while valid. Drop req 2 → RR resumes with 0 then 1.
- Backpressure: mig_cmd_full=1 for 10 cycles with req 0 valid → no req_ready, no mig_cmd_en. Release full → grant the same cycle, mig_cmd_en next cycle.
- Range error:
  - addr 3839744, bl 15 (end exactly 3840000) → issued, error=0.
  - Then addr 3839760, bl 15 from req 2 → acked, not issued, error=1, err_req=2.
  - A later bad command from req 0 leaves err_req=2.
- Reset mid-burst: rst low in the cycle mig_cmd_en=1 → next edge mig_cmd_en=0, error=0, and the next grant goes to req 0 first.
